seq_div_16b: RTL

Sequential restoring divider that inverts the 8x8 Wallace-tree multiplier: it takes a 2N-bit product-width dividend and an N-bit divisor and returns quotient and remainder, one quotient bit per clock. It sits next to the multiplier in the benchmark set as the multi-cycle, handshaked counterpart. It also serves as the exact reference when checking approximate multiplier outputs: feed `out0` back in and compare the recovered operand.

---
 rtl/seq_div_16b.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_div_16b.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIV_EARLY_EXIT_EN completes in one cycle when the dividend is below the divisor.
module seq_div_16b #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] in0,
  input  logic [N-1:0]   in1,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] out0,
  output logic [N-1:0]   out1,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state, state_d;
  logic [2*N-1:0] sr, sr_d;          // dividend bits shift out, quotient bits shift in
  logic [N-1:0]   dvsr, dvsr_d;
  logic [N:0]     rem, rem_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           busy_d, done_d, dz_d;
  logic [2*N-1:0] out0_d;
  logic [N-1:0]   out1_d;

  logic [N:0]     rem_sh;
  logic [N+1:0]   trial;
  logic           q_bit;
  logic [N:0]     rem_nx;
  logic           below_dvsr;

  // One restoring step: the sign of the trial difference is the next quotient bit.
  always_comb begin
    rem_sh     = {rem[N-1:0], sr[2*N-1]};
    trial      = {1'b0, rem_sh} - {2'b00, dvsr};
    q_bit      = ~trial[N+1];
    rem_nx     = q_bit ? trial[N:0] : rem_sh;
    below_dvsr = (in0 < {{N{1'b0}}, in1});
  end

  // NOTE: every target gets a default before the case, so no latches are inferred.
  always_comb begin
    state_d = state;
    sr_d    = sr;
    dvsr_d  = dvsr;
    rem_d   = rem;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = 1'b0;
    dz_d    = div_by_zero;
    out0_d  = out0;
    out1_d  = out1;

    case (state)
      IDLE: begin
        if (start) begin
          if (in1 == '0) begin
            out0_d = '1;
            out1_d = in0[N-1:0];
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else
`ifdef SEQ_DIV_EARLY_EXIT_EN
          if (below_dvsr) begin
            out0_d = '0;
            out1_d = in0[N-1:0];
            dz_d   = 1'b0;
            done_d = 1'b1;
          end else
`endif
          begin
            sr_d    = in0;
            dvsr_d  = in1;
            rem_d   = '0;
            cnt_d   = CW'(2*N);
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        sr_d  = {sr[2*N-2:0], q_bit};
        rem_d = rem_nx;
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          out0_d  = {sr[2*N-2:0], q_bit};
          out1_d  = rem_nx[N-1:0];
          dz_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      // NOTE: working registers are reset too, so an aborted division leaves nothing behind.
      sr          <= '0;
      dvsr        <= '0;
      rem         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      out0        <= '0;
      out1        <= '0;
    end else begin
      state       <= state_d;
      sr          <= sr_d;
      dvsr        <= dvsr_d;
      rem         <= rem_d;
      cnt         <= cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dz_d;
      out0        <= out0_d;
      out1        <= out1_d;
    end
  end

  // The early-exit comparator is only consumed when the macro is defined.
  logic unused_ok;
  assign unused_ok = below_dvsr;

endmodule
